// File: rtl/mem_access_ctrl_if.sv
// Core-side request/response signals and RAM-side byte bus of mem_access_ctrl.
// The controller connects through the slave modport, the requester/RAM side through master.
interface mem_access_ctrl_if #(
  parameter int LEN        = 32,
  parameter int ADDR_WIDTH = 17
);
  logic                  inst_req;
  logic [LEN-1:0]        inst_addr;
  logic                  inst_done;
  logic [LEN-1:0]        inst_out;
  logic                  data_req;
  logic                  data_we;
  logic [1:0]            data_size;
  logic                  data_signed;
  logic [LEN-1:0]        data_addr;
  logic [LEN-1:0]        data_wdata;
  logic                  data_done;
  logic [LEN-1:0]        data_rdata;
  logic                  inst_sel;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_wr;
  logic [7:0]            ram_dout;
  logic [7:0]            ram_din;

  modport slave (
    input  inst_req, inst_addr, data_req, data_we, data_size, data_signed,
           data_addr, data_wdata, ram_din,
    output inst_done, inst_out, data_done, data_rdata, inst_sel, busy,
           ram_addr, ram_wr, ram_dout
  );

  modport master (
    output inst_req, inst_addr, data_req, data_we, data_size, data_signed,
           data_addr, data_wdata, ram_din,
    input  inst_done, inst_out, data_done, data_rdata, inst_sel, busy,
           ram_addr, ram_wr, ram_dout
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Byte-serial memory access controller: one fetch or load/store at a time,
// little-endian byte sequencing over an 8-bit RAM with one-cycle read latency.
module mem_access_ctrl #(
  parameter int LEN        = 32,
  parameter int ADDR_WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy_in,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] base;
  logic [2:0]            nbytes;
  logic [2:0]            icnt;
  logic [2:0]            rcnt;
  logic [1:0]            size;
  logic                  sign_ext;
  logic                  fetch_sel;
  logic [LEN-1:0]        wdata;
  logic [LEN-1:0]        rbuf;
  logic [LEN-1:0]        inst_word;
  logic [LEN-1:0]        load_word;
  logic [LEN-1:0]        assembled;
  logic [LEN-1:0]        extended;
  logic [2:0]            req_bytes;
  logic                  last_byte;
  logic                  accept_data;
  logic                  accept_inst;
  logic                  capture;
  logic                  write_step;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic                  wr_c;
  logic [7:0]            dout_c;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{bus.inst_addr[LEN-1:ADDR_WIDTH], bus.data_addr[LEN-1:ADDR_WIDTH]};

  always_comb begin
    req_bytes = 3'd4;
    if (bus.data_size == 2'b00)
      req_bytes = 3'd1;
    else if (bus.data_size == 2'b01)
      req_bytes = 3'd2;
  end

  assign last_byte = (rcnt == nbytes - 3'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else if (rdy_in)
      state <= state_next;
  end

  // While stalled in READ, hold the oldest uncaptured address so the RAM output
  // on the resume cycle is exactly the byte that capture expects.
  always_comb begin
    state_next  = state;
    accept_data = 1'b0;
    accept_inst = 1'b0;
    capture     = 1'b0;
    write_step  = 1'b0;
    addr_c      = '0;
    wr_c        = 1'b0;
    dout_c      = 8'h00;
    case (state)
      IDLE: begin
        if (bus.data_req) begin
          addr_c = bus.data_addr[ADDR_WIDTH-1:0];
          if (bus.data_we) begin
            wr_c   = 1'b1;
            dout_c = bus.data_wdata[7:0];
          end
          accept_data = rdy_in;
          if (!bus.data_we)
            state_next = READ;
          else if (req_bytes == 3'd1)
            state_next = DONE;
          else
            state_next = WRITE;
        end else if (bus.inst_req) begin
          addr_c      = bus.inst_addr[ADDR_WIDTH-1:0];
          accept_inst = rdy_in;
          state_next  = READ;
        end
      end
      READ: begin
        addr_c  = base + ADDR_WIDTH'(rdy_in ? icnt : rcnt);
        capture = rdy_in;
        if (last_byte)
          state_next = DONE;
      end
      WRITE: begin
        addr_c     = base + ADDR_WIDTH'(icnt);
        wr_c       = 1'b1;
        dout_c     = wdata[{icnt[1:0], 3'b000} +: 8];
        write_step = rdy_in;
        if (icnt == nbytes - 3'd1)
          state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    assembled = rbuf;
    assembled[{rcnt[1:0], 3'b000} +: 8] = bus.ram_din;
    case (size)
      2'b00:   extended = {{(LEN-8){sign_ext & assembled[7]}}, assembled[7:0]};
      2'b01:   extended = {{(LEN-16){sign_ext & assembled[15]}}, assembled[15:0]};
      default: extended = assembled;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base      <= '0;
      nbytes    <= 3'd0;
      icnt      <= 3'd0;
      rcnt      <= 3'd0;
      size      <= 2'b00;
      sign_ext  <= 1'b0;
      fetch_sel <= 1'b0;
      wdata     <= '0;
      rbuf      <= '0;
      inst_word <= '0;
      load_word <= '0;
    end else if (rdy_in) begin
      if (accept_data || accept_inst) begin
        base      <= accept_data ? bus.data_addr[ADDR_WIDTH-1:0] : bus.inst_addr[ADDR_WIDTH-1:0];
        nbytes    <= accept_data ? req_bytes : 3'd4;
        size      <= accept_data ? bus.data_size : 2'b10;
        sign_ext  <= accept_data & bus.data_signed;
        fetch_sel <= accept_inst;
        wdata     <= bus.data_wdata;
        rbuf      <= '0;
        icnt      <= 3'd1;
        rcnt      <= 3'd0;
      end
      if (capture) begin
        rbuf <= assembled;
        rcnt <= rcnt + 3'd1;
        if (icnt < nbytes)
          icnt <= icnt + 3'd1;
        if (last_byte) begin
          if (fetch_sel)
            inst_word <= assembled;
          else
            load_word <= extended;
        end
      end
      if (write_step)
        icnt <= icnt + 3'd1;
    end
  end

  // In IDLE the access type is shown for the request about to win arbitration.
  assign bus.inst_sel   = (state == IDLE) ? (rst && bus.inst_req && !bus.data_req) : fetch_sel;
  assign bus.busy       = (state != IDLE);
  assign bus.inst_done  = (state == DONE) && fetch_sel;
  assign bus.data_done  = (state == DONE) && !fetch_sel;
  assign bus.inst_out   = inst_word;
  assign bus.data_rdata = load_word;
  assign bus.ram_addr   = rst ? addr_c : '0;
  assign bus.ram_wr     = rst && rdy_in && wr_c;
  assign bus.ram_dout   = rst ? dout_c : 8'h00;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Byte-serial memory access controller between the core's fetch/load-store logic and the 8-bit-wide unified RAM (17-bit byte address space). It accepts one 32-bit instruction-fetch request or one data load/store request (byte/half/word) at a time, sequences the byte transfers little-endian, assembles and sign/zero-extends loaded data, and returns a one-cycle done pulse. Its `inst_sel` output identifies the access type for the address/data steering logic.

## Interface
- `LEN`, 32, datapath width
- `ADDR_WIDTH`, 17, RAM byte-address width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted at 0)
- `rdy_in`  in  1  global ready; low = stall cycle
- `inst_req`  in  1  fetch request, held high until `inst_done`
- `inst_addr`  in  LEN  fetch byte address
- `inst_done`  out  1  one-cycle pulse, `inst_out` valid
- `inst_out`  out  LEN  fetched word
- `data_req`  in  1  load/store request, held high until `data_done`
- `data_we`  in  1  1 = store, 0 = load
- `data_size`  in  2  00 byte, 01 half, 10/11 word
- `data_signed`  in  1  loads: 1 sign-extend, 0 zero-extend
- `data_addr`  in  LEN  data byte address
- `data_wdata`  in  LEN  store data; low bytes used
- `data_done`  out  1  one-cycle pulse; for loads `data_rdata` valid
- `data_rdata`  out  LEN  extended load result
- `inst_sel`  out  1  1 while a fetch owns the RAM
- `busy`  out  1  high in any state other than IDLE
- `ram_addr`  out  ADDR_WIDTH  RAM byte address
- `ram_wr`  out  1  RAM write enable
- `ram_dout`  out  8  RAM write byte
- `ram_din`  in  8  RAM read byte (address presented one cycle earlier)

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: if `data_req`, accept data request (priority); else if `inst_req`, accept fetch. Latch base address (low ADDR_WIDTH bits), byte count n (1/2/4; fetch always 4), signedness, and write data. `inst_sel` = 1 for fetch, 0 for data, and is held until return to IDLE.
- Acceptance cycle is cycle 0. `ram_addr` is combinational: in IDLE it equals the winning request's address, or 0 if none.
- READ: issue counter `icnt` and capture counter `rcnt`. Each rdy cycle presents base+`icnt` and captures `ram_din` into byte `rcnt` when the previous rdy cycle presented that address. Bytes fill little-endian: byte k → bits [8k+7:8k].
- WRITE: cycle k (k = 0..n-1) drives `ram_addr` = base+k, `ram_dout` = wdata byte k, `ram_wr` = 1.
- Address arithmetic: base+k is computed modulo 2^ADDR_WIDTH. 0x1FFFF+1 wraps to 0x00000.
- After the last capture or write, go to DONE: pulse `inst_done` or `data_done` for exactly one cycle and update `inst_out`/`data_rdata`. Next cycle go to IDLE; requests are ignored in DONE.
- Load extension: byte → bit 7 or 0 into [31:8]; half → bit 15 or 0 into [31:16].
- `inst_out` and `data_rdata` hold their value until the next completion of the same type.

## Timing
- Reset (async, `rst`=0): state IDLE; counters 0; `inst_done`, `data_done`, `busy`, `inst_sel`, `ram_wr`, `inst_out`, `data_rdata`, `ram_dout` = 0. `ram_addr` = 0 during reset.
- Reset during an access abandons it: no done pulse. A partially written store may leave its earlier bytes written.
- Load/fetch of n bytes with no stalls: addresses in cycles 0..n-1, captures at the ends of cycles 1..n, done in cycle n+1. A word fetch has its done pulse in cycle 5.
- Store of n bytes: writes in cycles 0..n-1, done in cycle n.
- `rdy_in` low: no register changes and `ram_wr` is forced 0.
  - READ: `ram_addr` = base+`rcnt` (oldest uncaptured byte). On resume, that byte is captured and issue continues from `rcnt`+1, so no byte is lost or duplicated.
  - DONE: the done pulse extends through stall cycles.
- Requester must drop its request no later than the cycle after done. A request still high in the IDLE cycle after DONE is re-accepted as a new access.

## Test plan
- Word fetch: RAM[0x100..0x103] = 13,00,00,00; `inst_req` at 0x100 → `inst_done` in cycle 5, `inst_out` = 0x00000013, `inst_sel` = 1 in cycles 0-5.
- Signed byte load: RAM[0x20] = 0x80, size 00, `data_signed` = 1 → `data_rdata` = 0xFFFFFF80. With `data_signed` = 0 → 0x00000080.
- Half store then word load: store 0xBEEF at 0x40 → RAM[0x40] = EF, RAM[0x41] = BE, `data_done` in cycle 2, RAM[0x42] unchanged. A following word load at 0x40 returns 0x????BEEF.
- Simultaneous `inst_req` and `data_req` in IDLE: data serviced first (`inst_sel` = 0); fetch accepted in the IDLE cycle after `data_done`.
- Stall mid-read: word load at 0x1FFFE with `rdy_in` low for 3 cycles after cycle 1 → addresses 1FFFE, 1FFFF, 00000, 00001 are used. Result matches the no-stall value; done is delayed by 3 cycles. `ram_wr` stays 0.
- Reset asserted in cycle 2 of a word store → all outputs 0 immediately. Only bytes 0-1 are written; no `data_done`.
